// File: rtl/spb_gpio_irq_if.sv
// SPB slave port bundle: single request/ready handshake with byte strobes.
// The master drives the request fields and holds them stable until ready.
interface spb_gpio_irq_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output valid, wstb, addr, wdata, input ready, rdata);
   modport slave  (input valid, wstb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/spb_gpio_irq.sv
// GPIO bank on the SPB port: outputs with set/clear/toggle, output enables,
// synchronised inputs and per-pin edge interrupts with W1C status.
module spb_gpio_irq #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   spb_gpio_irq_if.slave    bus,
   input  logic [WIDTH-1:0] GPIO_I,
   output logic [WIDTH-1:0] GPIO_O,
   output logic [WIDTH-1:0] GPIO_OE,
   output logic             IRQ
);

   typedef enum logic {IDLE, ACK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] data_out_q, oe_q, rise_en_q, fall_en_q, status_q, mask_q;
   logic [WIDTH-1:0] data_out_d, oe_d, rise_en_d, fall_en_d, status_d, mask_d;
   logic [31:0]      rdata_q, rd_value, bm_full;
   logic             irq_q;
   logic             accept, wr;
   logic [3:0]       offset;
   logic [WIDTH-1:0] sync, hit, bm, wd, wm;
   logic             unused_addr;

   function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                              input logic [WIDTH-1:0] val,
                                              input logic [WIDTH-1:0] mask);
      merge = (old & ~mask) | (val & mask);
   endfunction

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      zext = '0;
      zext[WIDTH-1:0] = v;
   endfunction

   assign unused_addr = ^{bus.addr[31:6], bus.addr[1:0]};
   assign offset      = bus.addr[5:2];
   assign accept      = (state_q == IDLE) && bus.valid;
   assign wr          = accept && (bus.wstb != 4'h0);
   assign bm_full     = {{8{bus.wstb[3]}}, {8{bus.wstb[2]}}, {8{bus.wstb[1]}}, {8{bus.wstb[0]}}};
   assign bm          = bm_full[WIDTH-1:0];
   assign wd          = bus.wdata[WIDTH-1:0];
   assign wm          = wd & bm;

   assign sync = sync_q[SYNC_STAGES-1];
   assign hit  = (sync & ~prev_q & rise_en_q) | (~sync & prev_q & fall_en_q);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.valid) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_value = '0;
      case (offset)
         4'h0:    rd_value = zext(sync);
         4'h1:    rd_value = zext(data_out_q);
         4'h2:    rd_value = zext(oe_q);
         4'h6:    rd_value = zext(rise_en_q);
         4'h7:    rd_value = zext(fall_en_q);
         4'h8:    rd_value = zext(status_q);
         4'h9:    rd_value = zext(mask_q);
         default: rd_value = '0;
      endcase
   end

   // Register updates for the access accepted in IDLE; edge capture beats W1C.
   always_comb begin
      data_out_d = data_out_q;
      oe_d       = oe_q;
      rise_en_d  = rise_en_q;
      fall_en_d  = fall_en_q;
      mask_d     = mask_q;
      status_d   = status_q;
      if (wr) begin
         case (offset)
            4'h1:    data_out_d = merge(data_out_q, wd, bm);
            4'h2:    oe_d       = merge(oe_q, wd, bm);
            4'h3:    data_out_d = data_out_q | wm;
            4'h4:    data_out_d = data_out_q & ~wm;
            4'h5:    data_out_d = data_out_q ^ wm;
            4'h6:    rise_en_d  = merge(rise_en_q, wd, bm);
            4'h7:    fall_en_d  = merge(fall_en_q, wd, bm);
            4'h8:    status_d   = status_q & ~wm;
            4'h9:    mask_d     = merge(mask_q, wd, bm);
            default: ;
         endcase
      end
      status_d = status_d | hit;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q     <= '0;
         data_out_q <= '0;
         oe_q       <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         status_q   <= '0;
         mask_q     <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync_q[0] <= GPIO_I;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q     <= sync;
         data_out_q <= data_out_d;
         oe_q       <= oe_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         status_q   <= status_d;
         mask_q     <= mask_d;
         irq_q      <= |(status_q & mask_q);
         if (accept) rdata_q <= wr ? 32'h0 : rd_value;
      end
   end

   assign bus.ready = (state_q == ACK);
   assign bus.rdata = rdata_q;
   assign GPIO_O    = data_out_q;
   assign GPIO_OE   = oe_q;
   assign IRQ       = irq_q;

endmodule

// File: tb/tb_spb_gpio_irq.sv
// Bench for spb_gpio_irq: register-map model checked every cycle, directed
// literal sequences, randomized traffic, and a narrow build for width/reset.
module tb_spb_gpio_irq;
   localparam int SS = 2;
   localparam int K_RO = 0, K_RW = 1, K_SET = 2, K_CLR = 3, K_TGL = 4, K_W1C = 5;

   logic        clk = 1'b0;
   logic        rst_n, rst8_n;
   logic [31:0] gpio_i, gpio_o, gpio_oe;
   logic        irq;
   logic [7:0]  gpio8_i, gpio8_o, gpio8_oe;
   logic        irq8;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   spb_gpio_irq_if bus ();
   spb_gpio_irq_if bus8 ();

   spb_gpio_irq #(.WIDTH(32), .SYNC_STAGES(SS)) dut (
      .CLK(clk), .RST_N(rst_n), .bus(bus),
      .GPIO_I(gpio_i), .GPIO_O(gpio_o), .GPIO_OE(gpio_oe), .IRQ(irq));

   spb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(SS)) dut8 (
      .CLK(clk), .RST_N(rst8_n), .bus(bus8),
      .GPIO_I(gpio8_i), .GPIO_O(gpio8_o), .GPIO_OE(gpio8_oe), .IRQ(irq8));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: register table + input delay line
   logic [31:0] m_reg [16];
   logic [31:0] m_hist [$];
   bit          m_ack;
   logic [31:0] m_rdata;
   bit          m_irq;

   function automatic int kind(input int off);
      case (off)
         1, 2, 6, 7, 9: kind = K_RW;
         3:             kind = K_SET;
         4:             kind = K_CLR;
         5:             kind = K_TGL;
         8:             kind = K_W1C;
         default:       kind = K_RO;
      endcase
   endfunction

   function automatic logic [31:0] hist_at(input int ago);
      hist_at = (ago < m_hist.size()) ? m_hist[ago] : 32'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
         m_hist.delete();
         m_ack = 0;
         m_rdata = 32'h0;
         m_irq = 0;
      end else begin
         logic [31:0] sy, pv, hit, bm, wm;
         logic [31:0] nreg [16];
         int off;
         bit nirq;
         sy = hist_at(SS - 1);
         pv = hist_at(SS);
         hit = (sy & ~pv & m_reg[6]) | (~sy & pv & m_reg[7]);
         nirq = |(m_reg[8] & m_reg[9]);
         nreg = m_reg;
         if (m_ack) m_ack = 0;
         else if (bus.valid) begin
            off = int'(bus.addr[5:2]);
            bm = {{8{bus.wstb[3]}}, {8{bus.wstb[2]}}, {8{bus.wstb[1]}}, {8{bus.wstb[0]}}};
            wm = bus.wdata & bm;
            if (bus.wstb != 4'h0) begin
               m_rdata = 32'h0;
               case (kind(off))
                  K_RW:  nreg[off] = (m_reg[off] & ~bm) | wm;
                  K_SET: nreg[1] = m_reg[1] | wm;
                  K_CLR: nreg[1] = m_reg[1] & ~wm;
                  K_TGL: nreg[1] = m_reg[1] ^ wm;
                  K_W1C: nreg[8] = m_reg[8] & ~wm;
                  default: ;
               endcase
            end else if (off == 0) m_rdata = sy;
            else if (kind(off) == K_RW || kind(off) == K_W1C) m_rdata = m_reg[off];
            else m_rdata = 32'h0;
            m_ack = 1;
         end
         nreg[8] = nreg[8] | hit;
         m_reg = nreg;
         m_irq = nirq;
         m_hist.push_front(gpio_i);
         if (m_hist.size() > SS + 1) void'(m_hist.pop_back());
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("model_ready", {31'h0, bus.ready}, {31'h0, m_ack});
         check("model_gpio_o", gpio_o, m_reg[1]);
         check("model_gpio_oe", gpio_oe, m_reg[2]);
         check("model_irq", {31'h0, irq}, {31'h0, m_irq});
         if (m_ack) check("model_rdata", bus.rdata, m_rdata);
      end
   end

   // ---------------- stimulus
   task automatic xfer(input logic [5:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output logic [31:0] go);
      bus.valid = 1'b1;
      bus.addr  = {26'h0, a};
      bus.wstb  = s;
      bus.wdata = d;
      @(negedge clk);
      check("ready_pulse", {31'h0, bus.ready}, 32'h1);
      rd = bus.rdata;
      go = gpio_o;
      bus.valid = 1'b0;
      bus.wstb  = 4'h0;
      @(negedge clk);
      check("ready_single", {31'h0, bus.ready}, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, go;
      rst_n = 1'b0; rst8_n = 1'b0;
      gpio_i = '0; gpio8_i = '0;
      bus.valid = 1'b0; bus.wstb = '0; bus.addr = '0; bus.wdata = '0;
      bus8.valid = 1'b0; bus8.wstb = '0; bus8.addr = '0; bus8.wdata = '0;
      #22;
      check("rst_ready", {31'h0, bus.ready}, 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_gpio_o", gpio_o, 32'h0);
      check("rst_gpio_oe", gpio_oe, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; rst8_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         xfer(6'(i * 4), 4'h0, 32'h0, rd, go);
         check("reset_read", rd, 32'h0);
      end

      xfer(6'h04, 4'hF, 32'h0000_00F0, rd, go); check("data_out_wr", go, 32'h0000_00F0);
      xfer(6'h0C, 4'hF, 32'h0000_000F, rd, go); check("out_set", go, 32'h0000_00FF);
      xfer(6'h10, 4'hF, 32'h0000_0030, rd, go); check("out_clr", go, 32'h0000_00CF);
      xfer(6'h14, 4'hF, 32'h0000_0101, rd, go); check("out_tgl", go, 32'h0000_01CE);
      xfer(6'h04, 4'h2, 32'hFFFF_FFFF, rd, go); check("wstb_byte1", go, 32'h0000_FFCE);
      xfer(6'h0C, 4'h0, 32'h0, rd, go);         check("wo_reads_0", rd, 32'h0);
      xfer(6'h3C, 4'hF, 32'hFFFF_FFFF, rd, go); check("unmapped_wr", go, 32'h0000_FFCE);

      // rising edge on pin 0: status at edge 3, irq at edge 4
      xfer(6'h18, 4'hF, 32'h1, rd, go);
      xfer(6'h24, 4'hF, 32'h1, rd, go);
      gpio_i[0] = 1'b1;
      idle(3);
      check("irq_edge3", {31'h0, irq}, 32'h0);
      idle(1);
      check("irq_edge4", {31'h0, irq}, 32'h1);
      xfer(6'h00, 4'h0, 32'h0, rd, go); check("data_in", rd, 32'h1);
      xfer(6'h20, 4'h0, 32'h0, rd, go); check("status_rise", rd, 32'h1);
      gpio_i[0] = 1'b0;
      idle(5);
      xfer(6'h20, 4'h0, 32'h0, rd, go); check("fall_disabled", rd, 32'h1);

      // W1C committed at the same edge a fresh rising edge is captured
      gpio_i[0] = 1'b1;
      idle(2);
      xfer(6'h20, 4'hF, 32'h1, rd, go);
      check("w1c_race_irq", {31'h0, irq}, 32'h1);
      xfer(6'h20, 4'h0, 32'h0, rd, go); check("w1c_race_status", rd, 32'h1);
      xfer(6'h20, 4'hF, 32'h1, rd, go);
      check("w1c_irq_drop", {31'h0, irq}, 32'h0);
      xfer(6'h20, 4'h0, 32'h0, rd, go); check("w1c_status", rd, 32'h0);

      // pending status held off by mask
      xfer(6'h24, 4'hF, 32'h0, rd, go);
      xfer(6'h18, 4'hF, 32'h4, rd, go);
      gpio_i[2] = 1'b1;
      idle(5);
      check("masked_irq", {31'h0, irq}, 32'h0);
      xfer(6'h20, 4'h2, 32'hFFFF_FFFF, rd, go);
      xfer(6'h20, 4'h0, 32'h0, rd, go); check("w1c_unstrobed", rd, 32'h4);
      xfer(6'h24, 4'hF, 32'h4, rd, go);
      check("unmask_irq", {31'h0, irq}, 32'h1);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ ($urandom & $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
         xfer(6'($urandom_range(0, 15) * 4),
              ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
              $urandom, rd, go);
      end

      // narrow build: upper bits, then reset in the middle of ACK
      bus8.valid = 1'b1; bus8.addr = 32'h04; bus8.wstb = 4'hF; bus8.wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("w8_gpio_o", {24'h0, gpio8_o}, 32'h0000_00FF);
      bus8.valid = 1'b0; bus8.wstb = 4'h0;
      @(negedge clk);
      bus8.valid = 1'b1;
      @(negedge clk);
      check("w8_readback", bus8.rdata, 32'h0000_00FF);
      bus8.valid = 1'b0;
      @(negedge clk);
      bus8.valid = 1'b1; bus8.addr = 32'h08; bus8.wstb = 4'hF; bus8.wdata = 32'h3C;
      @(negedge clk);
      check("w8_ack_ready", {31'h0, bus8.ready}, 32'h1);
      rst8_n = 1'b0;
      bus8.valid = 1'b0; bus8.wstb = 4'h0;
      #1;
      check("w8_rst_ready", {31'h0, bus8.ready}, 32'h0);
      check("w8_rst_gpio_o", {24'h0, gpio8_o}, 32'h0);
      check("w8_rst_gpio_oe", {24'h0, gpio8_oe}, 32'h0);
      @(negedge clk);
      rst8_n = 1'b1;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
